// File: rtl/ibex_axi_bridge_if.sv
// AXI4 bus bundle between ibex_axi_bridge (master) and a single-beat AXI slave.
// The slave modport is the view used by memories and bus models.
interface ibex_axi_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/ibex_axi_bridge.sv
// Ibex-style req/gnt/rvalid data port to single-beat AXI4 master, one transaction in flight.
// Addresses outside the configured window are answered locally with an error.
module ibex_axi_bridge #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ID_WIDTH   = 1,
    parameter logic [ID_WIDTH-1:0]    AXI_ID     = '0,
    parameter logic [ADDR_WIDTH-1:0]  WIN_BASE   = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0]  WIN_SIZE   = 32'h4000_0000
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,

    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,

    ibex_axi_bridge_if.master       m_axi
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR_RESP
    } state_e;

    localparam logic [2:0]          LP_SIZE   = 3'($clog2(DATA_WIDTH / 8));
    // One extra bit so a window ending at the top of the address space does not wrap to 0.
    localparam logic [ADDR_WIDTH:0] LP_WIN_LO = {1'b0, WIN_BASE};
    localparam logic [ADDR_WIDTH:0] LP_WIN_HI = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};

    state_e                  r_state;
    state_e                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [DATA_WIDTH/8-1:0] r_be;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic [ADDR_WIDTH:0]     w_addr_ext;
    logic                    w_in_win;
    logic                    w_rsp_fire;
    logic                    w_rsp_err;
    logic [DATA_WIDTH-1:0]   w_rsp_data;
    logic                    w_unused_ok;

    assign w_addr_ext = {1'b0, addr_i};
    assign w_in_win   = (w_addr_ext >= LP_WIN_LO) && (w_addr_ext < LP_WIN_HI);

    always_comb begin
        w_state_next  = r_state;
        gnt_o         = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.rready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                gnt_o = req_i & m_axi_aresetn;
                if (gnt_o) begin
                    if (!w_in_win) begin
                        w_state_next = ERR_RESP;
                    end else if (we_i) begin
                        w_state_next = WR_REQ;
                    end else begin
                        w_state_next = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) w_state_next = RD_DATA;
            end
            RD_DATA: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) w_state_next = IDLE;
            end
            WR_REQ: begin
                m_axi.awvalid = ~r_aw_done;
                m_axi.wvalid  = ~r_w_done;
                if ((r_aw_done | m_axi.awready) && (r_w_done | m_axi.wready)) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) w_state_next = IDLE;
            end
            ERR_RESP: w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Response capture: writes and window errors return zero data.
    always_comb begin
        w_rsp_fire = ((r_state == RD_DATA) && m_axi.rvalid) ||
                     ((r_state == WR_RESP) && m_axi.bvalid) ||
                     (r_state == ERR_RESP);
        w_rsp_err  = (r_state == ERR_RESP) || (r_we ? m_axi.bresp[1] : m_axi.rresp[1]);
        w_rsp_data = ((r_state == ERR_RESP) || r_we) ? '0 : m_axi.rdata;
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= w_rsp_fire;
            if (gnt_o) begin
                r_addr    <= addr_i;
                r_we      <= we_i;
                r_be      <= be_i;
                r_wdata   <= wdata_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state == WR_REQ) begin
                if (m_axi.awready) r_aw_done <= 1'b1;
                if (m_axi.wready)  r_w_done  <= 1'b1;
            end
            if (w_rsp_fire) begin
                r_rdata <= w_rsp_data;
                r_err   <= w_rsp_err;
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = LP_SIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_be;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.arid    = AXI_ID;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = LP_SIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'd0;

    // IDs and rlast carry no information for single-beat, single-outstanding traffic.
    assign w_unused_ok = ^{m_axi.rid, m_axi.bid, m_axi.rlast, m_axi.rresp[0], m_axi.bresp[0]};

endmodule

// File: tb/tb_ibex_axi_bridge.sv
// Directed bench for ibex_axi_bridge: AXI slave model, bus monitor and response scoreboard.
module tb_ibex_axi_bridge;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    ibex_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) bus ();

    ibex_axi_bridge dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .we_i          (we_i),
        .be_i          (be_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .m_axi         (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int pulse_log[$];

    // Slave configuration
    int ar_delay, aw_delay, w_delay, r_delay, b_delay;
    logic [31:0] r_data;
    logic [1:0]  r_resp, b_resp;

    // Monitor observations
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int ar_hs_cyc, aw_hs_cyc, w_hs_cyc, aw_rise, w_rise, bready_rise;
    logic [31:0] ar_addr_seen, aw_addr_seen, wdata_seen;
    logic [7:0]  arlen_seen, awlen_seen;
    logic [2:0]  arsize_seen, awsize_seen;
    logic [1:0]  arburst_seen, awburst_seen;
    logic [3:0]  arcache_seen, awcache_seen, wstrb_seen;
    logic        ar_zero_seen, aw_zero_seen, wlast_seen, wvalid_at_aw_hs;
    int outstanding = 0, max_out = 0, stab_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // AXI slave: ready/valid driven 1 time unit after each rising edge.
    initial begin
        int ar_w, aw_w, w_w, r_w, b_w;
        ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = 1'b1;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1'b1;
        bus.rid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.arvalid) begin bus.arready = (ar_w >= ar_delay); ar_w++; end
            else begin bus.arready = 0; ar_w = 0; end
            if (bus.awvalid) begin bus.awready = (aw_w >= aw_delay); aw_w++; end
            else begin bus.awready = 0; aw_w = 0; end
            if (bus.wvalid) begin bus.wready = (w_w >= w_delay); w_w++; end
            else begin bus.wready = 0; w_w = 0; end
            if (bus.rready) begin
                bus.rvalid = (r_w >= r_delay); r_w++;
                bus.rdata = r_data; bus.rresp = r_resp;
            end else begin bus.rvalid = 0; r_w = 0; end
            if (bus.bready) begin
                bus.bvalid = (b_w >= b_delay); b_w++;
                bus.bresp = b_resp;
            end else begin bus.bvalid = 0; b_w = 0; end
        end
    end

    // Monitor and scoreboard, sampling on the falling edge.
    initial begin
        exp_t e;
        logic ar_pend, aw_pend, w_pend, bready_prev, awvalid_prev, wvalid_prev;
        ar_pend = 0; aw_pend = 0; w_pend = 0; bready_prev = 0; awvalid_prev = 0; wvalid_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
                bready_prev = 0; awvalid_prev = 0; wvalid_prev = 0;
            end else begin
                if ((ar_pend && !bus.arvalid) || (aw_pend && !bus.awvalid) ||
                    (w_pend && !bus.wvalid)) stab_err++;
                ar_pend = bus.arvalid && !bus.arready;
                aw_pend = bus.awvalid && !bus.awready;
                w_pend  = bus.wvalid && !bus.wready;
                if (bus.awvalid && !awvalid_prev) aw_rise = cyc;
                if (bus.wvalid && !wvalid_prev) w_rise = cyc;
                if (bus.bready && !bready_prev) bready_rise = cyc;
                awvalid_prev = bus.awvalid; wvalid_prev = bus.wvalid; bready_prev = bus.bready;
                if (bus.arvalid && bus.arready) begin
                    ar_cnt++; ar_hs_cyc = cyc; outstanding++;
                    ar_addr_seen = bus.araddr; arlen_seen = bus.arlen; arsize_seen = bus.arsize;
                    arburst_seen = bus.arburst; arcache_seen = bus.arcache;
                    ar_zero_seen = (bus.arlock == 0) && (bus.arprot == 0) && (bus.arqos == 0) &&
                                   (bus.arid == 0);
                end
                if (bus.awvalid && bus.awready) begin
                    aw_cnt++; aw_hs_cyc = cyc; outstanding++; wvalid_at_aw_hs = bus.wvalid;
                    aw_addr_seen = bus.awaddr; awlen_seen = bus.awlen; awsize_seen = bus.awsize;
                    awburst_seen = bus.awburst; awcache_seen = bus.awcache;
                    aw_zero_seen = (bus.awlock == 0) && (bus.awprot == 0) && (bus.awqos == 0) &&
                                   (bus.awid == 0);
                end
                if (bus.wvalid && bus.wready) begin
                    w_cnt++; w_hs_cyc = cyc;
                    wdata_seen = bus.wdata; wstrb_seen = bus.wstrb; wlast_seen = bus.wlast;
                end
                if (outstanding > max_out) max_out = outstanding;
                if ((bus.rvalid && bus.rready) || (bus.bvalid && bus.bready)) outstanding--;
                if (rvalid_o) begin
                    pulse_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_rvalid_o", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata_o", rdata_o, e.data);
                        check("err_o", err_o, e.err);
                    end
                end
            end
        end
    end

    task automatic do_req(input bit skip_edge, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_d,
                          input logic exp_e, output int gcyc);
        bit got;
        got = 0;
        gcyc = -1;
        if (!skip_edge) begin
            @(posedge clk);
            #1;
        end
        req_i = 1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (gnt_o) begin
                got = 1;
                gcyc = cyc;
                exp_q.push_back('{data: exp_d, err: exp_e});
            end
        end
        if (!got) check("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_i = 0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(posedge clk);
            #2;
            i++;
        end
        check({name, "_complete"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int g, g2, rel, ar_before;
        rst_n = 0; req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
        ar_delay = 0; aw_delay = 0; w_delay = 0; r_delay = 0; b_delay = 0;
        r_data = 0; r_resp = 0; b_resp = 0;
        repeat (3) @(posedge clk);
        #1;
        req_i = 1; addr_i = 32'h4000_0010;
        @(negedge clk);
        check("rst_gnt_o", gnt_o, 0);
        check("rst_rvalid_o", rvalid_o, 0);
        check("rst_err_o", err_o, 0);
        check("rst_rdata_o", rdata_o, 0);
        check("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid}, 0);
        check("rst_readies", {bus.bready, bus.rready}, 0);
        req_i = 0;

        // Single read; grant on the first edge after reset release
        ar_delay = 2; r_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst_n = 1;
        rel = cyc;
        do_req(1, 0, 32'h4000_0010, 4'hF, 0, 32'hDEAD_BEEF, 0, g);
        check("first_grant_cycle", g, rel);
        wait_done("read1");
        check("ar_count", ar_cnt, 1);
        check("araddr", ar_addr_seen, 32'h4000_0010);
        check("arlen", arlen_seen, 0);
        check("arsize", arsize_seen, 2);
        check("arburst", arburst_seen, 1);
        check("arcache", arcache_seen, 3);
        check("ar_zero_fields", ar_zero_seen, 1);
        check("ar_handshake_latency", ar_hs_cyc - g, 3);
        ar_delay = 0;

        // Write: W accepted 3 cycles before AW
        aw_delay = 3; w_delay = 0; b_delay = 1;
        do_req(0, 1, 32'h4000_0020, 4'b0011, 32'h1234_5678, 0, 0, g);
        wait_done("write1");
        check("aw_w_rise_together", aw_rise, w_rise);
        check("w_before_aw", aw_hs_cyc - w_hs_cyc, 3);
        check("wvalid_dropped_first", wvalid_at_aw_hs, 0);
        check("awaddr", aw_addr_seen, 32'h4000_0020);
        check("awlen_awsize", {awlen_seen, awsize_seen}, {8'd0, 3'd2});
        check("awburst_awcache", {awburst_seen, awcache_seen}, {2'b01, 4'b0011});
        check("aw_zero_fields", aw_zero_seen, 1);
        check("wstrb", wstrb_seen, 4'b0011);
        check("wdata", wdata_seen, 32'h1234_5678);
        check("wlast", wlast_seen, 1);
        check("bready_after_both", bready_rise, aw_hs_cyc + 1);
        aw_delay = 0; b_delay = 0;

        // Window errors and boundaries
        ar_before = ar_cnt;
        pulse_log.delete();
        do_req(0, 0, 32'h0000_1000, 4'hF, 0, 0, 1, g);
        wait_done("err_low");
        check("err_no_arvalid", ar_cnt, ar_before);
        check("err_pulse_latency", (pulse_log.size() == 1) ? pulse_log[0] - g : -1, 2);
        do_req(0, 0, 32'h3FFF_FFFC, 4'hF, 0, 0, 1, g);
        do_req(0, 1, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF, 0, 1, g);
        r_data = 32'hA5A5_0001;
        do_req(0, 0, 32'h7FFF_FFFC, 4'hF, 0, 32'hA5A5_0001, 0, g);
        wait_done("boundaries");
        check("boundary_ar_count", ar_cnt, ar_before + 1);

        // SLVERR write then DECERR read
        b_resp = 2'b10; r_resp = 2'b11; r_data = 32'hCAFE_F00D;
        do_req(0, 1, 32'h4000_0030, 4'hF, 32'h0BAD_0BAD, 0, 1, g);
        do_req(0, 0, 32'h4000_0034, 4'hF, 0, 32'hCAFE_F00D, 1, g);
        wait_done("errors");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_rdata_o", rdata_o, 32'hCAFE_F00D);
        check("hold_err_o", err_o, 1);
        b_resp = 0; r_resp = 0;

        // Reset while waiting in RD_DATA
        r_delay = 6;
        do_req(0, 0, 32'h4000_0040, 4'hF, 0, 0, 0, g);
        for (int i = 0; i < 50 && !bus.rready; i++) @(negedge clk);
        check("reached_rd_data", bus.rready, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_arvalid", bus.arvalid, 0);
        check("async_rst_rready", bus.rready, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        r_delay = 0;
        pulse_log.delete();
        repeat (8) @(posedge clk);
        check("no_pulse_after_reset", pulse_log.size(), 0);
        r_data = 32'h600D_F00D;
        do_req(0, 0, 32'h4000_0044, 4'hF, 0, 32'h600D_F00D, 0, g);
        wait_done("read_after_reset");

        // Back-to-back reads with req_i held high
        r_data = 32'h1111_2222; ar_delay = 1; r_delay = 1;
        pulse_log.delete();
        @(posedge clk);
        #1;
        req_i = 1; we_i = 0; be_i = 4'hF; addr_i = 32'h4000_0050;
        g = -1; g2 = -1;
        for (int i = 0; i < 50 && g < 0; i++) begin
            @(negedge clk);
            if (gnt_o) begin g = cyc; exp_q.push_back('{data: 32'h1111_2222, err: 1'b0}); end
        end
        @(posedge clk);
        #1;
        addr_i = 32'h4000_0054;
        for (int i = 0; i < 50 && g2 < 0; i++) begin
            @(negedge clk);
            if (gnt_o) begin g2 = cyc; exp_q.push_back('{data: 32'h1111_2222, err: 1'b0}); end
        end
        @(posedge clk);
        #1;
        req_i = 0;
        wait_done("b2b");
        check("b2b_pulse_count", pulse_log.size(), 2);
        check("b2b_grant_not_before_pulse",
              (g2 >= 0) && (pulse_log.size() > 0) && (g2 >= pulse_log[0]), 1);
        check("max_outstanding", max_out, 1);
        check("valid_stability_violations", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibex_axi_bridge.md
IBEX_AXI_BRIDGE -- requirements
Module: ibex_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both sides; legal values are 32 and 64.
REQ-003 SHALL have parameter ID_WIDTH, default 1, AXI ID width.
REQ-004 SHALL have parameter AXI_ID, default 0, ID driven on awid and arid.
REQ-005 SHALL have parameter WIN_BASE, default 32'h40000000, start of the legal address window.
REQ-006 SHALL have parameter WIN_SIZE, default 32'h40000000, size of the legal window in bytes.
REQ-007 SHALL have one clock and an asynchronous active-low reset: m_axi_aclk input 1 (clock); m_axi_aresetn input 1 (reset, asynchronous assert, active-low).
REQ-008 SHALL have the core-side ports: req_i input 1; gnt_o output 1; we_i input 1; be_i input DATA_WIDTH/8; addr_i input ADDR_WIDTH; wdata_i input DATA_WIDTH; rvalid_o output 1; rdata_o output DATA_WIDTH; err_o output 1.
REQ-009 SHALL have the AXI write-address ports: m_axi_awid, awaddr, awlen[8], awsize[3], awburst[2], awlock, awcache[4], awprot[3], awqos[4], awvalid (outputs); awready (input).
REQ-010 SHALL have the AXI write-data and response ports: wdata, wstrb, wlast, wvalid (outputs); wready (input); bid, bresp[2], bvalid (inputs); bready (output).
REQ-011 SHALL have the AXI read ports: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid (outputs); arready (input); rid, rdata, rresp[2], rlast, rvalid (inputs); rready (output).

Function
REQ-012 SHALL drive these AXI fields as constants: awlen/arlen=0; awsize/arsize=log2(DATA_WIDTH/8); awburst/arburst=2'b01; awlock/arlock=0; awcache/arcache=4'b0011; awprot/arprot=3'b000; awqos/arqos=0; wlast=1; awid/arid=AXI_ID.
REQ-013 SHALL use the FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and ERR_RESP, with exactly one transaction in flight at any time.
REQ-014 SHALL assert gnt_o = req_i combinationally in IDLE only, and SHALL register addr_i, we_i, be_i and wdata_i on the cycle gnt_o is high.
REQ-015 On a grant with the address outside [WIN_BASE, WIN_BASE+WIN_SIZE-1], SHALL go to ERR_RESP, issue no AXI traffic, and return to IDLE one cycle later.
REQ-016 SHALL evaluate the window in ADDR_WIDTH+1 bits so that a window reaching the top of the address space does not wrap.
REQ-017 On an in-window read grant, SHALL go to RD_ADDR and hold arvalid=1 with araddr set to the registered address until arready.
REQ-018 On the arvalid&arready cycle, SHALL go to RD_DATA, where rready=1.
REQ-019 On rvalid in RD_DATA, SHALL return to IDLE.
REQ-020 On an in-window write grant, SHALL go to WR_REQ with awvalid=1 and wvalid=1 together.
REQ-021 In WR_REQ, SHALL drop awvalid and wvalid independently after their own handshakes, in either order or in the same cycle.
REQ-022 SHALL enter WR_RESP on the cycle both the AW and W handshakes are complete.
REQ-023 In WR_RESP, SHALL hold bready=1 and return to IDLE on bvalid.
REQ-024 SHALL drive wstrb from the registered be and wdata from the registered wdata.
REQ-025 SHALL keep all AXI valid outputs stable until their handshake and SHALL never deassert a valid early.
REQ-026 SHALL give rvalid_o a registered one-cycle pulse on the cycle after rvalid&rready, bvalid&bready, or entry to ERR_RESP.
REQ-027 With rvalid_o, SHALL present rdata_o equal to the captured rdata for reads and 0 for writes and window errors.
REQ-028 SHALL set err_o=1 with rvalid_o when rresp[1] or bresp[1] is set, or on a window error, and 0 otherwise.
REQ-029 SHALL hold rdata_o and err_o between pulses.
REQ-030 SHALL ignore rid and bid.
REQ-031 SHALL hold gnt_o low while a response pulse is pending, so that a new grant occurs no earlier than the rvalid_o cycle.

Reset
REQ-032 While m_axi_aresetn=0, SHALL set the state to IDLE and hold gnt_o, rvalid_o, err_o, awvalid, wvalid, arvalid, bready and rready at 0, and rdata_o at 0.
REQ-033 On a reset in mid-transaction, SHALL discard the in-flight transaction with no response pulse after reset release.
REQ-034 SHALL leave the first grant possible on the first clock edge after reset deassertion.

Verification
REQ-035 Read at 0x40000010, arready after 2 cycles, rdata=0xDEADBEEF, rresp=OKAY -> one arvalid transfer with araddr=0x40000010 and arlen=0; rvalid_o pulses once with rdata_o=0xDEADBEEF and err_o=0.
REQ-036 Write at 0x40000020 with be=4'b0011 and wdata=0x12345678, wready before awready by 3 cycles -> wvalid drops first; bready rises only after both handshakes; rvalid_o pulses with err_o=0.
REQ-037 Read at 0x00001000 -> no arvalid; rvalid_o pulses 2 cycles after the grant with err_o=1 and rdata_o=0.
REQ-038 Write with bresp=2'b10 (SLVERR), then read with rresp=2'b11 (DECERR) -> both responses carry err_o=1, in order.
REQ-039 Reset asserted while in RD_DATA -> arvalid and rready are 0 immediately (asynchronous); no rvalid_o after release; a new read completes normally.
REQ-040 Back-to-back requests with req_i held high -> a second grant occurs only in or after the cycle of the first rvalid_o, and never more than one AXI transaction is outstanding.
